photo_hit_receiver: RTL
=======================

// Module: photo_hit_receiver
// PURPOSE
//   Receive side of the glove-laser link: samples the photo-sensor array, debounces each sensor, and arms
//   two target channels (A/B) against processor-selected target indices. Reports a held hit per channel
//   until the processor acknowledges it or moves the target. Sits between the photo_array pins and the
//   regfile hit-input registers. Replaces the free-running SR latches with a synchronous, debounced design.
// PARAMETERS
//   NUM_SENSORS      10     number of photo sensors; valid target indices are 0..NUM_SENSORS-1
//   DEBOUNCE_CYCLES  50000  consecutive agreeing samples needed to change a debounced level (1 ms @ 50 MHz)
//   CNT_W            16     debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//   clock        in   1            system clock; all state on rising edge
//   reset        in   1            synchronous, active-low reset
//   photo_array  in   NUM_SENSORS  raw sensor levels, asynchronous, 1 = laser light present
//   target_a     in   4            channel A target index, from the processor's target-1 register
//   target_b     in   4            channel B target index, from the processor's target-2 register
//   hit_ack_a    in   1            1-cycle pulse: processor has consumed hit_a
//   hit_ack_b    in   1            1-cycle pulse: processor has consumed hit_b
//   hit_a        out  1            channel A hit, held until ack or target change
//   hit_b        out  1            channel B hit, held until ack or target change
//   sensor_db    out  NUM_SENSORS  debounced sensor levels (debug / LED mirror)
// BEHAVIOUR
//   Reset (reset==0 at a rising edge): sync flops, debounce counters, sensor_db, hit_a and hit_b all go to 0.
//     Both channel FSMs go to WAIT_CLEAR. Stored old-target registers load the current target inputs.
//   Sync: photo_array passes through a 2-flop synchronizer (s).
//   Debounce, per sensor i:
//     - If s[i]==sensor_db[i], the counter clears to 0.
//     - Otherwise the counter increments. When it equals DEBOUNCE_CYCLES-1 while still mismatched,
//       sensor_db[i] <= s[i] and the counter clears.
//     - Result: an input change is visible on sensor_db 2+DEBOUNCE_CYCLES edges after it is first sampled.
//     - Glitches shorter than DEBOUNCE_CYCLES are ignored.
//   Channel FSM, identical for A and B; 'sel' = sensor_db[target], and 'sel' is 0 if target >= NUM_SENSORS:
//     - WAIT_CLEAR: goes to ARMED when sel==0. An invalid target therefore stays ARMED forever and never hits.
//     - ARMED: goes to HIT on sel==1. hit is asserted from the following edge (registered output).
//     - HIT: hit==1. Goes to WAIT_CLEAR on ack, so the same beam cannot re-trigger until it is released.
//   Target change: target != stored old-target register.
//     - From any state, the FSM goes to WAIT_CLEAR, hit clears the next edge, and the stored target updates.
//     - A target change wins over a simultaneous ack or sel rise.
//   Edge cases:
//     - An ack while not in HIT is ignored.
//     - target_a==target_b is legal; both channels hit on the same sensor edge.
//     - Reset mid-hit clears hit the same edge, with no ack required.
//   Total latency, raw rising edge to hit=1: 3+DEBOUNCE_CYCLES edges.
// STRUCTURE
//   ewh_pkg: typedef hit_state_t {WAIT_CLEAR, ARMED, HIT}; NUM_SENSORS_DEF=10; DEBOUNCE_DEF.
//   Sub-module sensor_debouncer (one sensor: sync + counter + level), generated NUM_SENSORS times.
//   Channel FSM written once as an always block per channel inside photo_hit_receiver.
// TESTING  (DEBOUNCE_CYCLES=4, so latency is 7 edges)
//   1. Reset, target_a=3, raise photo[3] and hold -> hit_a=1 exactly 7 edges later, hit_b stays 0.
//   2. Pulse photo[3] high for 3 cycles -> sensor_db[3] and hit_a stay 0.
//   3. hit_a=1, pulse hit_ack_a -> hit_a=0 next edge. Hold photo[3] high -> no re-hit. Drop it 7 cycles,
//      raise it again -> hit_a=1 again.
//   4. hit_a=1, change target_a 3->5 in the same cycle as hit_ack_a -> hit_a=0 next edge,
//      FSM in WAIT_CLEAR; photo[5] rise -> hit_a.
//   5. target_a=target_b=7, photo[7] rises -> hit_a and hit_b assert on the same edge.
//      target_a=12 with photo all 1s -> hit_a never asserts.
//   6. Assert reset for 1 cycle while hit_b=1 -> hit_b, sensor_db and counters = 0 next edge.

Source files
------------

// File: rtl/photo_hit_receiver_pkg.sv
// ewh_pkg: shared channel state type and default sizing for the photo hit receiver
package ewh_pkg;
  typedef enum logic [1:0] {WAIT_CLEAR, ARMED, HIT} hit_state_t;
  localparam int NUM_SENSORS_DEF = 10;
  localparam int DEBOUNCE_DEF = 50000;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/photo_hit_receiver_debouncer.sv
// sensor_debouncer: one photo sensor, 2-flop synchronizer followed by a consecutive-sample debounce counter
//   i_clk, i_rst_n (sync, active-low), i_raw async sensor level, o_db debounced level
module sensor_debouncer import ewh_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_db
);
  logic             r_s1, r_s2, r_db;
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_db) r_cnt <= '0;
      else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + CNT_W'(1);
    end
  assign o_db = r_db;
endmodule

// File: rtl/photo_hit_receiver.sv
// photo_hit_receiver: debounces the photo-sensor array and holds a hit per target channel until ack or retarget
//   i_clk, i_rst_n (sync, active-low), i_photo_array raw sensors, i_target_a/b target indices,
//   i_hit_ack_a/b ack pulses, o_hit_a/b held hits, o_sensor_db debounced sensor levels
module photo_hit_receiver import ewh_pkg::*; #(
  parameter int NUM_SENSORS = NUM_SENSORS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_SENSORS-1:0] i_photo_array,
  input  logic [3:0]             i_target_a,
  input  logic [3:0]             i_target_b,
  input  logic                   i_hit_ack_a,
  input  logic                   i_hit_ack_b,
  output logic                   o_hit_a,
  output logic                   o_hit_b,
  output logic [NUM_SENSORS-1:0] o_sensor_db
);
  logic [NUM_SENSORS-1:0] w_db;
  logic [1:0][3:0]        w_tgt;
  logic [1:0]             w_ack, w_hit;
  assign w_tgt = {i_target_b, i_target_a};
  assign w_ack = {i_hit_ack_b, i_hit_ack_a};
  for (genvar s = 0; s < NUM_SENSORS; s++) begin : g_sens
    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_raw  (i_photo_array[s]),
      .o_db   (w_db[s])
    );
  end
  for (genvar c = 0; c < 2; c++) begin : g_ch
    hit_state_t r_st;
    logic [3:0] r_old;
    logic       r_hit;
    logic       w_sel;
    // out-of-range targets read as dark, so such a channel arms but never hits
    assign w_sel = (32'(w_tgt[c]) < NUM_SENSORS) && w_db[w_tgt[c]];
    always_ff @(posedge i_clk)
      if (!i_rst_n) begin
        r_st  <= WAIT_CLEAR;
        r_hit <= 1'b0;
        r_old <= w_tgt[c];
      end else if (w_tgt[c] != r_old) begin
        r_st  <= WAIT_CLEAR;
        r_hit <= 1'b0;
        r_old <= w_tgt[c];
      end else
        case (r_st)
          WAIT_CLEAR: if (!w_sel) r_st <= ARMED;
          ARMED: if (w_sel) begin
            r_st  <= HIT;
            r_hit <= 1'b1;
          end
          HIT: if (w_ack[c]) begin
            r_st  <= WAIT_CLEAR;
            r_hit <= 1'b0;
          end
          default: begin
            r_st  <= WAIT_CLEAR;
            r_hit <= 1'b0;
          end
        endcase
    assign w_hit[c] = r_hit;
  end
  assign o_hit_a     = w_hit[0];
  assign o_hit_b     = w_hit[1];
  assign o_sensor_db = w_db;
endmodule
